// File: rtl/popcount_stream_neuron.sv
// Popcount stream neuron: accumulates FRAMES beats of ternary-weighted bits
// (+1 for in_pos only, -1 for in_neg only, 0 for both or neither) into a signed
// sum. The result is then held with a registered ternary activation until the
// consumer takes it.
//
// Handshake rules (both sides): a transfer happens on a rising clk edge where
// valid=1 and ready=1. in_ready depends only on state, never on in_valid.
// out_valid stays 1 and out_sum/out_act stay stable until the transfer edge.
module popcount_stream_neuron #(
  parameter int N      = 25,
  parameter int FRAMES = 4,
  parameter int THR    = 0,
  localparam int CW    = $clog2(N + 1),
  localparam int SW    = $clog2(FRAMES * N + 1) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_pos,
  input  logic [N-1:0]         in_neg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [SW-1:0] out_sum,
  output logic [1:0]           out_act,
  output logic [1:0]           dbg_state_o
);

  localparam int CNTW = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(FRAMES - 1);
  localparam logic signed [SW-1:0] THR_POS = SW'(THR);
  localparam logic signed [SW-1:0] THR_NEG = -THR_POS;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Stage 1 registers
  logic [CW-1:0] pos_cnt_q, neg_cnt_q;
  logic          s1_valid_q, s1_last_q;

  // Stage 2 / output registers
  logic signed [SW-1:0] acc_q, acc_d;
  logic signed [SW-1:0] out_sum_q, out_sum_d;
  logic [1:0]           out_act_q, out_act_d;

  logic                 accept;
  logic [N-1:0]         pos_only, neg_only;
  logic signed [SW-1:0] beat_delta, sum_next;

  function automatic logic [CW-1:0] popcount(input logic [N-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Symmetric dead zone: |sum| <= THR maps to zero.
  function automatic logic [1:0] act_of(input logic signed [SW-1:0] s);
    if (s > THR_POS) begin
      return 2'b01;
    end else if (s < THR_NEG) begin
      return 2'b11;
    end else begin
      return 2'b00;
    end
  endfunction

  assign accept   = in_valid && (state_q == ST_ACC);
  // Bits set in both vectors cancel, so they are masked out of both counts.
  assign pos_only = in_pos & ~in_neg;
  assign neg_only = in_neg & ~in_pos;

  // SW exceeds CW, so zero-extended counts are non-negative as signed values.
  assign beat_delta = $signed(SW'(pos_cnt_q)) - $signed(SW'(neg_cnt_q));
  assign sum_next   = acc_q + beat_delta;

  assign in_ready    = (state_q == ST_ACC);
  assign out_valid   = (state_q == ST_HOLD);
  assign out_sum     = out_sum_q;
  assign out_act     = out_act_q;
  assign dbg_state_o = state_q;

  // Stage 1: register masked popcounts of the accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_cnt_q  <= '0;
      neg_cnt_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
    end else begin
      s1_valid_q <= accept;
      s1_last_q  <= accept && (cnt_q == LAST_CNT);
      if (accept) begin
        pos_cnt_q <= popcount(pos_only);
        neg_cnt_q <= popcount(neg_only);
      end
    end
  end

  // Next-state, beat counter, accumulator and result capture.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    out_sum_d = out_sum_q;
    out_act_d = out_act_q;

    if (s1_valid_q) begin
      acc_d = sum_next;
    end
    // The last beat leaves stage 1 during DRAIN; capture the final sum and
    // its activation together so both appear on the same edge.
    if (s1_valid_q && s1_last_q) begin
      out_sum_d = sum_next;
      out_act_d = act_of(sum_next);
    end

    case (state_q)
      ST_ACC: begin
        if (accept) begin
          if (cnt_q == LAST_CNT) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d   = ST_ACC;
          cnt_d     = '0;
          acc_d     = '0;
          out_sum_d = '0;
          out_act_d = 2'b00;
        end
      end
      default: begin
        state_d = ST_ACC;
        cnt_d   = '0;
        acc_d   = '0;
      end
    endcase
  end

  // State, counter, accumulator and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      cnt_q     <= '0;
      acc_q     <= '0;
      out_sum_q <= '0;
      out_act_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      out_sum_q <= out_sum_d;
      out_act_q <= out_act_d;
    end
  end

endmodule

// File: tb/tb_popcount_stream_neuron.sv
// Bench for popcount_stream_neuron: two instances (THR=0 and THR=3) share one
// stimulus stream; expected sums come from a per-bit ternary rule model.
module tb_popcount_stream_neuron;

  localparam int N      = 25;
  localparam int FRAMES = 4;
  localparam int SW     = $clog2(FRAMES * N + 1) + 1;
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, out_ready;
  logic [N-1:0]  in_pos, in_neg;
  logic          in_ready_a, in_ready_b, out_valid_a, out_valid_b;
  logic [SW-1:0] out_sum_a, out_sum_b;
  logic [1:0]    out_act_a, out_act_b, dbg_a, dbg_b;

  popcount_stream_neuron #(.N(N), .FRAMES(FRAMES), .THR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_pos(in_pos), .in_neg(in_neg), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_sum(out_sum_a), .out_act(out_act_a),
    .dbg_state_o(dbg_a)
  );

  popcount_stream_neuron #(.N(N), .FRAMES(FRAMES), .THR(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pos(in_pos), .in_neg(in_neg), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_sum(out_sum_b), .out_act(out_act_b),
    .dbg_state_o(dbg_b)
  );

  // Scoreboard
  logic [SW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  logic [N-1:0] fr_pos [FRAMES];
  logic [N-1:0] fr_neg [FRAMES];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: ternary weight of one beat, straight from the bit rules.
  function automatic int beat_val(input logic [N-1:0] p, input logic [N-1:0] n);
    int v;
    v = 0;
    for (int i = 0; i < N; i++) begin
      if (p[i] && !n[i]) v = v + 1;
      else if (n[i] && !p[i]) v = v - 1;
    end
    return v;
  endfunction

  function automatic logic [1:0] act_of(input int s, input int thr);
    if (s > thr) return 2'b01;
    if (s < -thr) return 2'b11;
    return 2'b00;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready_a"}, 32'(in_ready_a), 32'd1);
    chk({tag, "_in_ready_b"}, 32'(in_ready_b), 32'd1);
    chk({tag, "_out_valid"}, 32'({out_valid_a, out_valid_b}), 32'd0);
    chk({tag, "_out_sum"}, 32'({out_sum_a, out_sum_b}), 32'd0);
    chk({tag, "_out_act"}, 32'({out_act_a, out_act_b}), 32'd0);
  endtask

  // Driver: called at a negedge, returns at the negedge after acceptance.
  task automatic send_beat(input logic [N-1:0] p, input logic [N-1:0] n);
    int w;
    in_pos = p;
    in_neg = n;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready_a && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("beat_ready", 32'(in_ready_a), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_pos = N'($urandom);
    in_neg = N'($urandom);
  endtask

  task automatic run_frame(input int max_gap);
    int sum;
    sum = 0;
    for (int k = 0; k < FRAMES; k++) begin
      sum += beat_val(fr_pos[k], fr_neg[k]);
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_pos = N'($urandom);
        in_neg = N'($urandom);
        @(negedge clk);
      end
      send_beat(fr_pos[k], fr_neg[k]);
    end
    exp_q.push_back(SW'(sum));
    chk("drain_out_valid", 32'(out_valid_a), 32'd0);
    chk("drain_in_ready", 32'(in_ready_a), 32'd0);
    @(negedge clk);
    chk("latency_out_valid", 32'({out_valid_a, out_valid_b}), 32'd3);
  endtask

  task automatic collect(input int hold, input bit noisy);
    int w, s;
    logic [SW-1:0] e;
    logic [1:0] ea, eb;
    w = 0;
    while (!out_valid_a && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("result_valid", 32'(out_valid_a), 32'd1);
    e = exp_q.pop_front();
    s = int'($signed(e));
    ea = act_of(s, 0);
    eb = act_of(s, 3);
    chk("sum_thr0", 32'(out_sum_a), 32'(e));
    chk("sum_thr3", 32'(out_sum_b), 32'(e));
    chk("act_thr0", 32'(out_act_a), 32'(ea));
    chk("act_thr3", 32'(out_act_b), 32'(eb));
    repeat (hold) begin
      out_ready = 1'b0;
      in_valid = noisy ? 1'($urandom) : 1'b0;
      in_pos = N'($urandom);
      in_neg = N'($urandom);
      @(negedge clk);
      chk("hold_stable", 32'(out_valid_a && out_valid_b && !in_ready_a && !in_ready_b &&
          out_sum_a === e && out_sum_b === e && out_act_a === ea && out_act_b === eb), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("after_hs_out_valid", 32'(out_valid_a), 32'd0);
    chk("after_hs_in_ready", 32'(in_ready_a), 32'd1);
  endtask

  task automatic set_frame(input logic [N-1:0] p, input logic [N-1:0] n);
    for (int k = 0; k < FRAMES; k++) begin
      fr_pos[k] = p;
      fr_neg[k] = n;
    end
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_pos = '0;
    in_neg = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All-ones positive: +25 per beat
    set_frame(ALL_ONES, '0);
    run_frame(0);
    collect(0, 1'b0);

    // +12 - 13 per beat
    set_frame(25'h0000FFF, 25'h1FFF000);
    run_frame(2);
    collect(1, 1'b0);

    // Full overlap cancels
    set_frame(ALL_ONES, ALL_ONES);
    run_frame(1);
    collect(0, 1'b0);

    // Backpressure with in_valid noise in HOLD, then next frame from zero
    set_frame(ALL_ONES, '0);
    run_frame(0);
    collect(10, 1'b1);
    set_frame(25'h1, '0);
    run_frame(0);
    collect(0, 1'b0);

    // Reset after two beats discards the partial sum
    send_beat(ALL_ONES, '0);
    send_beat(ALL_ONES, '0);
    #2 rst_n = 1'b0;
    #1 check_idle("reset_mid_acc");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_frame(25'h1, '0);
    run_frame(0);
    collect(0, 1'b0);

    // Reset while holding a result discards it
    set_frame(ALL_ONES, 25'h3);
    run_frame(0);
    #2 rst_n = 1'b0;
    #1 check_idle("reset_in_hold");
    void'(exp_q.pop_front());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("no_valid_after_reset", 32'({out_valid_a, out_valid_b}), 32'd0);
    end

    // Threshold edges: +3, +4, -3, -4
    set_frame('0, '0);
    fr_pos[0] = 25'h7;
    run_frame(0);
    collect(0, 1'b0);
    set_frame(25'h1, '0);
    run_frame(0);
    collect(0, 1'b0);
    set_frame('0, '0);
    fr_neg[0] = 25'h7;
    run_frame(0);
    collect(0, 1'b0);
    set_frame('0, 25'h1);
    run_frame(0);
    collect(0, 1'b0);

    // Random traffic
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < FRAMES; k++) begin
        fr_pos[k] = N'($urandom);
        fr_neg[k] = N'($urandom);
        if (f % 3 == 0) fr_neg[k] = fr_neg[k] & N'($urandom);
      end
      run_frame(3);
      collect($urandom_range(0, 4), 1'b1);
    end

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
